// File: rtl/cp0_timer_int.sv
// cp0_timer_int -- CP0 Compare register, Cause timer bits and timer
// interrupt request handshake.
//
// Takes the free-running Count value from the Count register block and
// compares it against Compare (CP0 reg 11). A match sets Cause.TI (which is
// mirrored onto IP7). The request to the exception stage is held through a
// req/ack handshake, and each timer event is requested once: a new request
// needs a Compare rewrite to clear TI first.
//
// Optional build macro CP0_TIMER_MASK_EN: adds a Status shadow (CP0 reg 12)
// holding IE (bit 0), EXL (bit 1) and IM7 (bit 15). A request is raised only
// when IE=1, IM7=1 and EXL=0. TI itself is never masked.
//
// Ports:
//   clk         clock
//   resetn      asynchronous active-low reset
//   cp0_en      CP0 access valid this cycle
//   cp0_wen     1 = mtc0 write, 0 = mfc0 read
//   cp0_addr    CP0 register number
//   cp0_wdata   mtc0 data
//   count_val   current Count value
//   cp0_rdata   mfc0 data, 0 for addresses not owned here (OR-mergeable)
//   ti_pending  Cause.TI
//   int_req     timer interrupt request to the exception stage
//   int_ack     exception stage has taken the interrupt
//
// Handshake FSM:
//   state    | meaning
//   IDLE     | no request outstanding, waiting for TI
//   REQ      | int_req asserted, waiting for int_ack (or TI cleared)
//   SERVICED | event taken, waiting for TI to clear before re-arming

module cp0_timer_int #(
  parameter logic [4:0] CMP_ADDR   = 5'd11,
  parameter logic [4:0] CAUSE_ADDR = 5'd13,
  parameter int         TI_BIT     = 30,
  parameter int         IP_BIT     = 15
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cp0_en,
  input  logic        cp0_wen,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  input  logic [31:0] count_val,
  output logic [31:0] cp0_rdata,
  output logic        ti_pending,
  output logic        int_req,
  input  logic        int_ack
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    SERVICED = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] compare;
  logic [31:0] count_q;
  logic        armed;
  logic        match;
  logic        match_q;
  logic        ti_hold;
  logic        ti;
  logic        cmp_wr;
  logic        rd_en;
  logic        req_ok;

  assign cmp_wr = cp0_en & cp0_wen & (cp0_addr == CMP_ADDR);
  assign rd_en  = cp0_en & ~cp0_wen;

  // Edge-qualified match: only the cycle Count steps onto Compare counts, so
  // a Count that holds for several cycles cannot re-trigger.
  assign match = armed & (count_val == compare) & (count_val != count_q);

  // TI is the registered match OR the sticky copy of earlier matches, so it
  // rises one edge after Count arrives on Compare.
  assign ti         = ti_hold | match_q;
  assign ti_pending = ti;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      compare <= '0;
      count_q <= '0;
      armed   <= 1'b0;
      match_q <= 1'b0;
      ti_hold <= 1'b0;
    end else begin
      count_q <= count_val;
      if (cmp_wr) begin
        // A write in the same cycle as a match wins: the match is dropped.
        compare <= cp0_wdata;
        armed   <= 1'b1;
        match_q <= 1'b0;
        ti_hold <= 1'b0;
      end else begin
        match_q <= match;
        ti_hold <= ti_hold | match_q;
      end
    end
  end

`ifdef CP0_TIMER_MASK_EN
  localparam logic [4:0] STATUS_ADDR = 5'd12;

  logic st_ie;
  logic st_exl;
  logic st_im7;
  logic st_wr;

  assign st_wr = cp0_en & cp0_wen & (cp0_addr == STATUS_ADDR);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st_ie  <= 1'b0;
      st_exl <= 1'b0;
      st_im7 <= 1'b0;
    end else if (st_wr) begin
      st_ie  <= cp0_wdata[0];
      st_exl <= cp0_wdata[1];
      st_im7 <= cp0_wdata[15];
    end
  end

  assign req_ok = st_ie & st_im7 & ~st_exl;
`else
  assign req_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    int_req   = 1'b0;
    case (state)
      IDLE: begin
        if (ti && req_ok) begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        int_req = 1'b1;
        if (!ti) begin
          state_nxt = IDLE;
        end else if (int_ack) begin
          state_nxt = SERVICED;
        end
      end
      SERVICED: begin
        if (!ti) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    cp0_rdata = '0;
    if (rd_en) begin
      if (cp0_addr == CMP_ADDR) begin
        cp0_rdata = compare;
      end else if (cp0_addr == CAUSE_ADDR) begin
        cp0_rdata[TI_BIT] = ti;
        cp0_rdata[IP_BIT] = ti;
      end
`ifdef CP0_TIMER_MASK_EN
      else if (cp0_addr == STATUS_ADDR) begin
        cp0_rdata[0]  = st_ie;
        cp0_rdata[1]  = st_exl;
        cp0_rdata[15] = st_im7;
      end
`endif
    end
  end

endmodule

// File: tb/tb_cp0_timer_int.sv
module tb_cp0_timer_int;

  logic        clk;
  logic        resetn;
  logic        cp0_en;
  logic        cp0_wen;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic [31:0] count_val;
  logic [31:0] cp0_rdata;
  logic        ti_pending;
  logic        int_req;
  logic        int_ack;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: architectural state of the timer and the outstanding
  // request, advanced once per clock edge from the inputs seen at that edge.
  logic [31:0] m_cmp;
  logic [31:0] m_prev;
  bit          m_armed;
  bit          m_ti;
  bit          m_req;
  bit          m_served;
  bit          m_ie;
  bit          m_exl;
  bit          m_im7;

  cp0_timer_int dut (
    .clk        (clk),
    .resetn     (resetn),
    .cp0_en     (cp0_en),
    .cp0_wen    (cp0_wen),
    .cp0_addr   (cp0_addr),
    .cp0_wdata  (cp0_wdata),
    .count_val  (count_val),
    .cp0_rdata  (cp0_rdata),
    .ti_pending (ti_pending),
    .int_req    (int_req),
    .int_ack    (int_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_cmp    = '0;
    m_prev   = '0;
    m_armed  = 0;
    m_ti     = 0;
    m_req    = 0;
    m_served = 0;
    m_ie     = 0;
    m_exl    = 0;
    m_im7    = 0;
  endtask

  task automatic model_update();
    bit wr_cmp;
    bit hit;
    bit ok;
    if (!resetn) begin
      model_reset();
      return;
    end
    wr_cmp = cp0_en && cp0_wen && (cp0_addr == 5'd11);
    hit    = m_armed && (count_val == m_cmp) && (count_val != m_prev);
    ok     = 1;
`ifdef CP0_TIMER_MASK_EN
    ok = m_ie && m_im7 && !m_exl;
`endif
    if (m_req) begin
      if (!m_ti) m_req = 0;
      else if (int_ack) begin
        m_req    = 0;
        m_served = 1;
      end
    end else if (m_served) begin
      if (!m_ti) m_served = 0;
    end else if (m_ti && ok) begin
      m_req = 1;
    end
    if (wr_cmp) begin
      m_cmp   = cp0_wdata;
      m_armed = 1;
      m_ti    = 0;
    end else if (hit) begin
      m_ti = 1;
    end
`ifdef CP0_TIMER_MASK_EN
    if (cp0_en && cp0_wen && cp0_addr == 5'd12) begin
      m_ie  = cp0_wdata[0];
      m_exl = cp0_wdata[1];
      m_im7 = cp0_wdata[15];
    end
`endif
    m_prev = count_val;
  endtask

  function automatic logic [31:0] m_read();
    logic [31:0] v;
    v = 32'h0;
    if (cp0_en && !cp0_wen) begin
      if (cp0_addr == 5'd11) v = m_cmp;
      else if (cp0_addr == 5'd13) v = (32'(m_ti) << 30) | (32'(m_ti) << 15);
`ifdef CP0_TIMER_MASK_EN
      else if (cp0_addr == 5'd12) v = 32'(m_ie) | (32'(m_exl) << 1) | (32'(m_im7) << 15);
`endif
    end
    return v;
  endfunction

  // Advance one clock: model sees the inputs in the middle of the cycle,
  // DUT outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(negedge clk);
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    cp0_en    = 1'b1;
    cp0_wen   = 1'b1;
    cp0_addr  = a;
    cp0_wdata = d;
    step();
    cp0_en    = 1'b0;
    cp0_wen   = 1'b0;
  endtask

  task automatic read_reg(input logic [4:0] a);
    cp0_en   = 1'b1;
    cp0_wen  = 1'b0;
    cp0_addr = a;
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] ramp [6];
    ramp = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h1};
    resetn    = 1'b0;
    count_val = 32'd5;
    #1;
    n_checks++;
    if (int_req !== 1'b0 || ti_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: int_req=%b ti=%b, expected 0 0", int_req, ti_pending);
    end
    model_reset();
    step();
    step();
    #2 resetn = 1'b1;
    step();
    for (int i = 0; i < 6; i++) begin
      count_val = ramp[i];
      step();
      n_checks++;
      if (ti_pending !== 1'b0 || int_req !== 1'b0) begin
        n_fail++;
        $display("FAIL unarmed_pass_zero[%0d]: ti=%b int_req=%b, expected 0 0", i, ti_pending, int_req);
      end
    end
    read_reg(5'd11);
    n_checks++;
    if (cp0_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_compare_read: got %h expected 00000000", cp0_rdata);
    end
    read_reg(5'd13);
    n_checks++;
    if (cp0_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_cause_read: got %h expected 00000000", cp0_rdata);
    end
    cp0_en = 1'b0;
  endtask

  task automatic test_match();
    logic [31:0] ramp [4];
    ramp = '{32'h0E, 32'h0E, 32'h0F, 32'h0F};
    count_val = 32'h0D;
`ifdef CP0_TIMER_MASK_EN
    write_reg(5'd12, 32'h0000_8001);
`endif
    write_reg(5'd11, 32'h10);
    for (int i = 0; i < 4; i++) begin
      count_val = ramp[i];
      step();
      n_checks++;
      if (ti_pending !== 1'b0) begin
        n_fail++;
        $display("FAIL pre_match_ti[%0d]: got %b expected 0", i, ti_pending);
      end
    end
    count_val = 32'h10;
    step();
    n_checks++;
    if (ti_pending !== 1'b1 || int_req !== 1'b0) begin
      n_fail++;
      $display("FAIL match_ti_latency: ti=%b int_req=%b, expected 1 0", ti_pending, int_req);
    end
    read_reg(5'd13);
    n_checks++;
    if (cp0_rdata !== 32'h4000_8000) begin
      n_fail++;
      $display("FAIL cause_read: got %h expected 40008000", cp0_rdata);
    end
    cp0_en = 1'b0;
    step();
    n_checks++;
    if (int_req !== 1'b1) begin
      n_fail++;
      $display("FAIL int_req_rise: got %b expected 1", int_req);
    end
  endtask

  task automatic test_ack();
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    n_checks++;
    if (int_req !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_drop: int_req=%b expected 0", int_req);
    end
    step();
    count_val = 32'h11;
    step();
    n_checks++;
    if (int_req !== 1'b0 || ti_pending !== 1'b1) begin
      n_fail++;
      $display("FAIL no_rerequest: int_req=%b ti=%b, expected 0 1", int_req, ti_pending);
    end
    write_reg(5'd11, 32'h20);
    n_checks++;
    if (ti_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL rewrite_clears_ti: got %b expected 0", ti_pending);
    end
    step();
    count_val = 32'h1F;
    step();
    count_val = 32'h20;
    step();
    step();
    n_checks++;
    if (int_req !== 1'b1 || ti_pending !== 1'b1) begin
      n_fail++;
      $display("FAIL second_event_req: int_req=%b ti=%b, expected 1 1", int_req, ti_pending);
    end
    write_reg(5'd11, 32'h30);
    n_checks++;
    if (ti_pending !== 1'b0 || int_req !== 1'b1) begin
      n_fail++;
      $display("FAIL req_after_rewrite: ti=%b int_req=%b, expected 0 1", ti_pending, int_req);
    end
    step();
    n_checks++;
    if (int_req !== 1'b0) begin
      n_fail++;
      $display("FAIL req_withdrawn: int_req=%b expected 0", int_req);
    end
  endtask

  task automatic test_collision();
    count_val = 32'h2F;
    step();
    step();
    count_val = 32'h30;
    cp0_en    = 1'b1;
    cp0_wen   = 1'b1;
    cp0_addr  = 5'd11;
    cp0_wdata = 32'h40;
    step();
    cp0_en  = 1'b0;
    cp0_wen = 1'b0;
    n_checks++;
    if (ti_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL collision_ti: got %b expected 0", ti_pending);
    end
    step();
    step();
    n_checks++;
    if (ti_pending !== 1'b0 || int_req !== 1'b0) begin
      n_fail++;
      $display("FAIL collision_hold: ti=%b int_req=%b, expected 0 0", ti_pending, int_req);
    end
    count_val = 32'h3F;
    step();
    step();
    count_val = 32'h40;
    step();
    n_checks++;
    if (ti_pending !== 1'b1) begin
      n_fail++;
      $display("FAIL new_compare_match: got %b expected 1", ti_pending);
    end
    step();
    n_checks++;
    if (int_req !== 1'b1) begin
      n_fail++;
      $display("FAIL new_compare_req: got %b expected 1", int_req);
    end
  endtask

  task automatic test_async_reset();
    #2 resetn = 1'b0;
    #1;
    n_checks++;
    if (int_req !== 1'b0 || ti_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_drop: int_req=%b ti=%b, expected 0 0", int_req, ti_pending);
    end
    read_reg(5'd11);
    n_checks++;
    if (cp0_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset_compare: got %h expected 00000000", cp0_rdata);
    end
    cp0_en = 1'b0;
    model_reset();
    step();
    #2 resetn = 1'b1;
    step();
    n_checks++;
    if (int_req !== 1'b0 || ti_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: int_req=%b ti=%b, expected 0 0", int_req, ti_pending);
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_rd;
    int r;
    count_val = 32'hFFFF_FFE0 + 32'($urandom_range(0, 15));
    for (int i = 0; i < 3000; i++) begin
      if (i % 2 == 0) count_val = count_val + 32'd1;
      if ($urandom_range(0, 99) == 0) count_val = $urandom;
      r         = $urandom_range(0, 99);
      cp0_en    = 1'b0;
      cp0_wen   = 1'($urandom_range(0, 1));
      cp0_addr  = 5'($urandom_range(0, 31));
      cp0_wdata = $urandom;
      if (r < 8) begin
        cp0_en    = 1'b1;
        cp0_wen   = 1'b1;
        cp0_addr  = 5'd11;
        cp0_wdata = count_val + 32'($urandom_range(1, 6));
      end else if (r < 12) begin
        cp0_en    = 1'b1;
        cp0_wen   = 1'b1;
        cp0_addr  = 5'd12;
        cp0_wdata = ($urandom_range(0, 3) != 0) ? 32'h0000_8001 : $urandom;
      end else if (r < 50) begin
        cp0_en   = 1'b1;
        cp0_wen  = 1'b0;
        cp0_addr = ($urandom_range(0, 3) == 0) ? cp0_addr : 5'($urandom_range(11, 13));
      end
      int_ack = ($urandom_range(0, 3) == 0);
      #1;
      exp_rd = m_read();
      n_checks++;
      if (cp0_rdata !== exp_rd) begin
        n_fail++;
        $display("FAIL rand_rdata[%0d]: got %h expected %h", i, cp0_rdata, exp_rd);
      end
      n_checks++;
      if (ti_pending !== m_ti) begin
        n_fail++;
        $display("FAIL rand_ti[%0d]: got %b expected %b", i, ti_pending, m_ti);
      end
      n_checks++;
      if (int_req !== m_req) begin
        n_fail++;
        $display("FAIL rand_int_req[%0d]: got %b expected %b", i, int_req, m_req);
      end
      step();
    end
    cp0_en  = 1'b0;
    cp0_wen = 1'b0;
    int_ack = 1'b0;
  endtask

`ifdef CP0_TIMER_MASK_EN
  task automatic test_mask();
    resetn = 1'b0;
    #1;
    model_reset();
    step();
    #2 resetn = 1'b1;
    count_val = 32'h100;
    step();
    write_reg(5'd12, 32'h0000_8000);
    write_reg(5'd11, 32'h102);
    count_val = 32'h101;
    step();
    step();
    count_val = 32'h102;
    step();
    n_checks++;
    if (ti_pending !== 1'b1) begin
      n_fail++;
      $display("FAIL mask_ti_set: got %b expected 1", ti_pending);
    end
    step();
    step();
    n_checks++;
    if (int_req !== 1'b0) begin
      n_fail++;
      $display("FAIL mask_blocks_req: got %b expected 0", int_req);
    end
    write_reg(5'd12, 32'h0000_8001);
    read_reg(5'd12);
    n_checks++;
    if (cp0_rdata !== 32'h0000_8001) begin
      n_fail++;
      $display("FAIL status_read: got %h expected 00008001", cp0_rdata);
    end
    cp0_en = 1'b0;
    step();
    n_checks++;
    if (int_req !== 1'b1) begin
      n_fail++;
      $display("FAIL unmask_req: got %b expected 1", int_req);
    end
  endtask
`endif

  initial begin
    resetn    = 1'b0;
    cp0_en    = 1'b0;
    cp0_wen   = 1'b0;
    cp0_addr  = 5'd0;
    cp0_wdata = 32'h0;
    count_val = 32'd5;
    int_ack   = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_match();
    test_ack();
    test_collision();
    test_async_reset();
    test_random();
`ifdef CP0_TIMER_MASK_EN
    test_mask();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
